// File: rtl/per2axi_rsp_channel.sv
`default_nettype none
// ============================================================================
// Module   : per2axi_rsp_channel
// Summary  : AXI R/B beats to one-hot peripheral responses; the atomic R/B
//            merge is built only when PER2AXI_RSP_ATOP_EN is defined.
// Revision : 1.0
// ============================================================================
module per2axi_rsp_channel #(
   parameter int PER_ID_WIDTH   = 5,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int AXI_USER_WIDTH = 6,
   parameter int AXI_ID_WIDTH   = 3
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   output logic                      per_slave_r_valid_o,
   output logic                      per_slave_r_opc_o,
   output logic [PER_ID_WIDTH-1:0]   per_slave_r_id_o,
   output logic [31:0]               per_slave_r_rdata_o,
   input  logic                      trans_req_i,
   input  logic [AXI_ID_WIDTH-1:0]   trans_id_i,
   input  logic [AXI_ADDR_WIDTH-1:0] trans_add_i,
   input  logic                      atop_req_i,
   input  logic [AXI_ID_WIDTH-1:0]   atop_id_i,
   input  logic [AXI_ADDR_WIDTH-1:0] atop_add_i,
   input  logic                      axi_master_r_valid_i,
   input  logic [AXI_DATA_WIDTH-1:0] axi_master_r_data_i,
   input  logic [1:0]                axi_master_r_resp_i,
   input  logic                      axi_master_r_last_i,
   input  logic [AXI_ID_WIDTH-1:0]   axi_master_r_id_i,
   input  logic [AXI_USER_WIDTH-1:0] axi_master_r_user_i,
   output logic                      axi_master_r_ready_o,
   input  logic                      axi_master_b_valid_i,
   input  logic [1:0]                axi_master_b_resp_i,
   input  logic [AXI_ID_WIDTH-1:0]   axi_master_b_id_i,
   input  logic [AXI_USER_WIDTH-1:0] axi_master_b_user_i,
   output logic                      axi_master_b_ready_o
);

   localparam int c_NUM_IDS = 2**AXI_ID_WIDTH;

   logic [c_NUM_IDS-1:0]    r_lane;
   logic                    r_rsp_valid;
   logic                    r_rsp_opc;
   logic [PER_ID_WIDTH-1:0] r_rsp_id;
   logic [31:0]             r_rsp_rdata;

   logic                    w_r_hs;
   logic                    w_b_hs;
   logic [AXI_ID_WIDTH-1:0] w_hs_id;
   logic [31:0]             w_lane_data;
   logic                    w_beat_err;
   logic                    w_rsp_valid;
   logic                    w_rsp_opc;
   logic [31:0]             w_rsp_data;
   logic [PER_ID_WIDTH-1:0] w_rsp_id;
   logic                    w_unused;

`ifdef PER2AXI_RSP_ATOP_EN
   logic [c_NUM_IDS-1:0] r_atop_pend;
   logic [c_NUM_IDS-1:0] r_r_seen;
   logic [c_NUM_IDS-1:0] r_b_seen;
   logic [c_NUM_IDS-1:0] r_err;
   logic [31:0]          r_data [c_NUM_IDS];
   logic                 w_first_beat;
   logic                 w_last_beat;

   assign w_unused = ^{axi_master_r_last_i, axi_master_r_user_i, axi_master_b_user_i,
                       trans_add_i, atop_add_i};
`else
   assign w_unused = ^{axi_master_r_last_i, axi_master_r_user_i, axi_master_b_user_i,
                       trans_add_i, atop_req_i, atop_id_i, atop_add_i};
`endif

   // R always wins; B is only taken in a cycle without an R beat.
   assign axi_master_r_ready_o = 1'b1;
   assign axi_master_b_ready_o = ~axi_master_r_valid_i;

   always_comb begin
      w_r_hs      = axi_master_r_valid_i;
      w_b_hs      = axi_master_b_valid_i & ~axi_master_r_valid_i;
      w_hs_id     = w_r_hs ? axi_master_r_id_i : axi_master_b_id_i;
      w_lane_data = r_lane[axi_master_r_id_i] ? axi_master_r_data_i[63:32]
                                              : axi_master_r_data_i[31:0];
      w_beat_err  = w_r_hs ? axi_master_r_resp_i[1] : axi_master_b_resp_i[1];
      w_rsp_valid = w_r_hs | w_b_hs;
      w_rsp_opc   = w_beat_err;
      w_rsp_data  = w_r_hs ? w_lane_data : {31'b0, axi_master_b_resp_i != 2'b01};
`ifdef PER2AXI_RSP_ATOP_EN
      w_first_beat = 1'b0;
      w_last_beat  = 1'b0;
      if (w_rsp_valid && r_atop_pend[w_hs_id]) begin
         if ((w_r_hs && r_b_seen[w_hs_id]) || (w_b_hs && r_r_seen[w_hs_id])) begin
            w_last_beat = 1'b1;
            w_rsp_opc   = r_err[w_hs_id] | w_beat_err;
            w_rsp_data  = w_r_hs ? w_lane_data : r_data[w_hs_id];
         end else begin
            w_first_beat = 1'b1;
            w_rsp_valid  = 1'b0;
         end
      end
`endif
   end

   // One-hot ID; AXI IDs beyond PER_ID_WIDTH map to all zeros.
   for (genvar gi = 0; gi < PER_ID_WIDTH; gi++) begin : g_id_oh
      assign w_rsp_id[gi] = (32'(w_hs_id) == gi);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_lane <= '0;
      end else begin
         if (trans_req_i) r_lane[trans_id_i] <= trans_add_i[2];
`ifdef PER2AXI_RSP_ATOP_EN
         if (atop_req_i)  r_lane[atop_id_i]  <= atop_add_i[2];
`endif
      end
   end

`ifdef PER2AXI_RSP_ATOP_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_atop_pend <= '0;
         r_r_seen    <= '0;
         r_b_seen    <= '0;
         r_err       <= '0;
      end else begin
         if (w_first_beat) begin
            if (w_r_hs) r_r_seen[w_hs_id] <= 1'b1;
            else        r_b_seen[w_hs_id] <= 1'b1;
            r_err[w_hs_id] <= r_err[w_hs_id] | w_beat_err;
         end
         if (w_last_beat) begin
            r_atop_pend[w_hs_id] <= 1'b0;
            r_r_seen[w_hs_id]    <= 1'b0;
            r_b_seen[w_hs_id]    <= 1'b0;
            r_err[w_hs_id]       <= 1'b0;
         end
         // A new atomic on the ID re-arms its entry after any completion above.
         if (atop_req_i) begin
            r_atop_pend[atop_id_i] <= 1'b1;
            r_r_seen[atop_id_i]    <= 1'b0;
            r_b_seen[atop_id_i]    <= 1'b0;
            r_err[atop_id_i]       <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_first_beat && w_r_hs) r_data[w_hs_id] <= w_lane_data;
   end
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rsp_valid <= 1'b0;
         r_rsp_opc   <= 1'b0;
         r_rsp_id    <= '0;
         r_rsp_rdata <= '0;
      end else begin
         r_rsp_valid <= w_rsp_valid;
         r_rsp_opc   <= w_rsp_valid & w_rsp_opc;
         r_rsp_id    <= w_rsp_valid ? w_rsp_id : '0;
         r_rsp_rdata <= w_rsp_valid ? w_rsp_data : '0;
      end
   end

   assign per_slave_r_valid_o = r_rsp_valid;
   assign per_slave_r_opc_o   = r_rsp_opc;
   assign per_slave_r_id_o    = r_rsp_id;
   assign per_slave_r_rdata_o = r_rsp_rdata;

endmodule
`default_nettype wire
